mcs4_bus_fabric: RTL and testbench

- Parametrised 4-bit MCS-4 system data-bus fabric, the successor to the fixed three-driver wired-OR bus in the MCS-4 system top.
- Merges N chip bus drivers and tracks the 8-phase instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3) from sync.
- Captures each fetch address/opcode pair into an instruction-trace FIFO with a valid/ready read port.
- Detects driver contention.
- Sits between i4004 CPU, i4001 ROMs and i4002 RAMs in the system top.

---
 rtl/mcs4_bus_fabric_pkg.sv | 24 ++
 rtl/mcs4_sync_fifo.sv | 56 +++++
 rtl/mcs4_bus_fabric.sv | 133 +++++++++++++
 tb/tb_mcs4_bus_fabric.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcs4_bus_fabric_pkg.sv
// Shared MCS-4 bus-fabric types: nibble, instruction-cycle phase and trace entry.
package mcs4_bus_fabric_pkg;

  typedef logic [3:0] char_t;

  typedef enum logic [2:0] {
    A1 = 3'd0,
    A2 = 3'd1,
    A3 = 3'd2,
    M1 = 3'd3,
    M2 = 3'd4,
    X1 = 3'd5,
    X2 = 3'd6,
    X3 = 3'd7
  } phase_t;

  localparam int TRACE_W = 20;

  typedef struct packed {
    logic [11:0] pc;
    logic [7:0]  opcode;
  } trace_entry_t;

endpackage

// File: rtl/mcs4_sync_fifo.sv
// Synchronous FIFO with valid/ready read port; a push while full (and not
// popping) is dropped and latches a sticky overflow flag.
module mcs4_sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign rd_valid = (count != '0);
  assign pop_ok   = pop & rd_valid;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok  = push & (~full | pop_ok);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push & ~push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mcs4_bus_fabric.sv
// MCS-4 data-bus fabric: wired-OR merge of N drivers, 8-phase cycle tracker,
// fetch-trace capture into a FIFO and driver contention detection.
module mcs4_bus_fabric
  import mcs4_bus_fabric_pkg::*;
#(
  parameter int NUM_DRV       = 3,
  parameter int NUM_RAM_BANKS = 4,
  parameter int TRACE_DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clken_1,
  input  logic                     clken_2,
  input  logic                     sync,
  input  logic [NUM_RAM_BANKS-1:0] cm_ram,
  input  logic [4*NUM_DRV-1:0]     d_drv,
  output logic [3:0]               d_bus,
  output logic [2:0]               phase,
  output logic                     locked,
  output logic [NUM_RAM_BANKS-1:0] bank_sel,
  output logic                     contention,
  output logic [7:0]               contention_cnt,
  output logic                     trace_valid,
  output logic [TRACE_W-1:0]       trace_data,
  input  logic                     trace_ready,
  output logic                     trace_overflow
);

  phase_t       phase_q, phase_d;
  logic         locked_q, locked_d;
  logic [11:0]  pc_cap;
  char_t        op_hi_cap;
  char_t        bus_or;
  logic         seen_drv;
  logic         multi_drv_p0;
  logic         cap_en;
  logic         push;
  trace_entry_t push_entry;
  logic         unused_ok;

  assign unused_ok = clken_1;

  // Stage p0: combinational merge and multi-driver detection
  always_comb begin
    bus_or       = '0;
    seen_drv     = 1'b0;
    multi_drv_p0 = 1'b0;
    for (int i = 0; i < NUM_DRV; i++) begin
      if (d_drv[4*i +: 4] != 4'h0) begin
        if (seen_drv) multi_drv_p0 = 1'b1;
        seen_drv = 1'b1;
      end
      bus_or = bus_or | d_drv[4*i +: 4];
    end
  end

  assign d_bus = bus_or;

  always_comb begin
    phase_d  = phase_q;
    locked_d = locked_q;
    if (clken_2) begin
      if (sync) begin
        phase_d  = A1;
        locked_d = 1'b1;
      end else if (locked_q) begin
        phase_d = phase_t'(phase_q + 3'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= X3;
      locked_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      locked_q <= locked_d;
    end
  end

  assign phase  = phase_q;
  assign locked = locked_q;
  assign cap_en = locked_q & clken_2;

  // Stage p1: capture registers, keyed on the phase being left this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_cap    <= '0;
      op_hi_cap <= '0;
      bank_sel  <= '0;
    end else if (cap_en) begin
      case (phase_q)
        A1:      pc_cap[3:0]  <= d_bus;
        A2:      pc_cap[7:4]  <= d_bus;
        A3:      pc_cap[11:8] <= d_bus;
        M1:      op_hi_cap    <= d_bus;
        X2:      bank_sel     <= cm_ram;
        default: ;
      endcase
    end
  end

  // The low opcode nibble goes straight from the bus into the pushed entry.
  assign push       = cap_en & (phase_q == M2);
  assign push_entry = {pc_cap, op_hi_cap, d_bus};

  always_ff @(posedge clk) begin
    if (rst) begin
      contention     <= 1'b0;
      contention_cnt <= '0;
    end else begin
      contention <= clken_2 & multi_drv_p0;
      if (clken_2 & multi_drv_p0 & (contention_cnt != 8'hFF))
        contention_cnt <= contention_cnt + 8'd1;
    end
  end

  mcs4_sync_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (clken_2 & trace_ready),
    .rd_valid  (trace_valid),
    .rd_data   (trace_data),
    .overflow  (trace_overflow)
  );

endmodule

// File: tb/tb_mcs4_bus_fabric.sv
// Directed bench for mcs4_bus_fabric with a queue scoreboard of expected trace entries.
module tb_mcs4_bus_fabric;

  logic        clk = 1'b0;
  logic        rst;
  logic        clken_1;
  logic        clken_2;
  logic        sync;
  logic [3:0]  cm_ram;
  logic [11:0] d_drv;
  logic [3:0]  d_bus;
  logic [2:0]  phase;
  logic        locked;
  logic [3:0]  bank_sel;
  logic        contention;
  logic [7:0]  contention_cnt;
  logic        trace_valid;
  logic [19:0] trace_data;
  logic        trace_ready;
  logic        trace_overflow;

  int n_checks = 0;
  int n_fails  = 0;
  logic [19:0] sb_q[$];
  logic        exp_ovf = 1'b0;

  always #5 clk = ~clk;

  mcs4_bus_fabric #(
    .NUM_DRV       (3),
    .NUM_RAM_BANKS (4),
    .TRACE_DEPTH   (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clken_1        (clken_1),
    .clken_2        (clken_2),
    .sync           (sync),
    .cm_ram         (cm_ram),
    .d_drv          (d_drv),
    .d_bus          (d_bus),
    .phase          (phase),
    .locked         (locked),
    .bank_sel       (bank_sel),
    .contention     (contention),
    .contention_cnt (contention_cnt),
    .trace_valid    (trace_valid),
    .trace_data     (trace_data),
    .trace_ready    (trace_ready),
    .trace_overflow (trace_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction fetch starting from any phase; leaves the tracker in X1 with sync raised.
  task automatic fetch(input logic [11:0] pc, input logic [7:0] op, input bit pop_m2);
    logic [19:0] head;
    sync = 1'b1; d_drv = '0; tick();
    sync = 1'b0;
    d_drv = {8'h00, pc[3:0]};  tick();
    d_drv = {8'h00, pc[7:4]};  tick();
    d_drv = {8'h00, pc[11:8]}; tick();
    d_drv = {4'h0, op[7:4], 4'h0}; tick();
    d_drv = {4'h0, op[3:0], 4'h0};
    if (pop_m2) begin
      head = sb_q.pop_front();
      chk("m2pop_valid", {31'd0, trace_valid}, 32'd1);
      chk("m2pop_head", {12'd0, trace_data}, {12'd0, head});
      trace_ready = 1'b1;
    end
    tick();
    trace_ready = 1'b0;
    d_drv = '0;
    sync = 1'b1;
    if (sb_q.size() < 8) sb_q.push_back({pc, op});
    else exp_ovf = 1'b1;
  endtask

  task automatic drain();
    logic [19:0] exp;
    while (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      chk("drain_valid", {31'd0, trace_valid}, 32'd1);
      chk("drain_data", {12'd0, trace_data}, {12'd0, exp});
      trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;
    end
    chk("drain_empty", {31'd0, trace_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clken_1 = 1'b1; clken_2 = 1'b0; sync = 1'b0;
    cm_ram = '0; d_drv = 12'h050; trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clken_2 = ~clken_2;
      tick();
    end
    chk("rst_dbus", {28'd0, d_bus}, 32'h5);
    chk("rst_phase", {29'd0, phase}, 32'd7);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_valid", {31'd0, trace_valid}, 32'd0);
    chk("rst_data", {12'd0, trace_data}, 32'd0);
    chk("rst_ovf", {31'd0, trace_overflow}, 32'd0);
    chk("rst_cnt", {24'd0, contention_cnt}, 32'd0);
    chk("rst_cont", {31'd0, contention}, 32'd0);
    chk("rst_bank", {28'd0, bank_sel}, 32'd0);

    rst = 1'b0; clken_2 = 1'b1; d_drv = '0;
    tick(); tick();
    chk("unlocked_phase", {29'd0, phase}, 32'd7);
    chk("unlocked_locked", {31'd0, locked}, 32'd0);

    fetch(12'h124, 8'hD3, 1'b0);
    chk("fetch_valid", {31'd0, trace_valid}, 32'd1);
    chk("fetch_data", {12'd0, trace_data}, 32'h124D3);
    chk("fetch_phase", {29'd0, phase}, 32'd5);
    chk("fetch_locked", {31'd0, locked}, 32'd1);
    drain();

    // Occupancy 1: push and pop together, new entry becomes head.
    fetch(12'h0AB, 8'h11, 1'b0);
    fetch(12'h0CD, 8'h22, 1'b1);
    chk("occ1_data", {12'd0, trace_data}, 32'h0CD22);
    drain();

    // Full FIFO: push with simultaneous pop keeps occupancy and no overflow.
    for (int i = 0; i < 8; i++)
      fetch(12'h200 + 12'(i * 17), 8'h40 + 8'(i), 1'b0);
    fetch(12'h2FF, 8'h4F, 1'b1);
    chk("fullpop_ovf", {31'd0, trace_overflow}, 32'd0);
    chk("fullpop_occ", sb_q.size(), 32'd8);
    drain();

    // Nine fetches without popping: ninth dropped, overflow sticky.
    for (int i = 0; i < 9; i++)
      fetch(12'h500 + 12'(i * 33), 8'h90 + 8'(i), 1'b0);
    chk("ovf_flag", {31'd0, trace_overflow}, {31'd0, exp_ovf});
    chk("ovf_const", {31'd0, trace_overflow}, 32'd1);
    drain();
    chk("ovf_sticky", {31'd0, trace_overflow}, 32'd1);

    // Contention: two non-zero drivers.
    d_drv = 12'h021; #1;
    chk("cont_dbus", {28'd0, d_bus}, 32'h3);
    chk("cont_before", {31'd0, contention}, 32'd0);
    tick();
    chk("cont_pulse", {31'd0, contention}, 32'd1);
    chk("cont_cnt1", {24'd0, contention_cnt}, 32'd1);
    d_drv = 12'h020;
    tick();
    chk("cont_single", {31'd0, contention}, 32'd0);
    d_drv = 12'h021; clken_2 = 1'b0;
    tick();
    chk("cont_noen", {31'd0, contention}, 32'd0);
    chk("cont_noen_cnt", {24'd0, contention_cnt}, 32'd1);
    clken_2 = 1'b1;
    repeat (300) tick();
    chk("cont_sat", {24'd0, contention_cnt}, 32'd255);
    chk("cont_hold", {31'd0, contention}, 32'd1);
    d_drv = '0;
    tick();
    chk("cont_release", {31'd0, contention}, 32'd0);
    chk("cont_sat_keep", {24'd0, contention_cnt}, 32'd255);

    // Bank select in X2, then a missed sync wraps X3 to A1.
    fetch(12'h3A7, 8'h5C, 1'b0);
    sync = 1'b0; cm_ram = 4'b0010;
    tick(); tick();
    cm_ram = 4'b0000;
    chk("bank_sel", {28'd0, bank_sel}, 32'h2);
    chk("x3_phase", {29'd0, phase}, 32'd7);
    tick();
    chk("miss_phase", {29'd0, phase}, 32'd0);
    chk("miss_locked", {31'd0, locked}, 32'd1);
    d_drv = 12'h00E; tick();
    d_drv = 12'h00F; tick();
    d_drv = 12'h001; tick();
    chk("pre_rst_phase", {29'd0, phase}, 32'd3);
    rst = 1'b1; d_drv = 12'h090;
    tick();
    rst = 1'b0;
    sb_q.delete();
    chk("mrst_phase", {29'd0, phase}, 32'd7);
    chk("mrst_locked", {31'd0, locked}, 32'd0);
    chk("mrst_valid", {31'd0, trace_valid}, 32'd0);
    chk("mrst_bank", {28'd0, bank_sel}, 32'd0);
    chk("mrst_cnt", {24'd0, contention_cnt}, 32'd0);
    repeat (10) tick();
    chk("nosync_phase", {29'd0, phase}, 32'd7);
    chk("nosync_locked", {31'd0, locked}, 32'd0);
    chk("nosync_valid", {31'd0, trace_valid}, 32'd0);
    sync = 1'b1;
    tick();
    chk("relock_phase", {29'd0, phase}, 32'd0);
    chk("relock_locked", {31'd0, locked}, 32'd1);
    fetch(12'hABC, 8'h12, 1'b0);
    chk("relock_data", {12'd0, trace_data}, 32'hABC12);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
